ofm_drain: RTL and testbench

- Read-side counterpart of the PE result path.
- PEs pack 8-bit MAC results into 32-bit words (shift register) and write them into per-PE OFM memories. ofm_drain walks those memories, issues word reads, and unpacks each word into a byte stream with a valid/ready handshake.
- Sits beside data_path and is started by the controller after convolution completes.
- Drains CH_NUM channels in order 0..CH_NUM-1.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/word_unpacker.sv | 78 +++++++
 rtl/ofm_drain.sv | 169 ++++++++++++++++
 tb/tb_ofm_drain.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the OFM read-back path.
//   - drain_state_t : state encoding of the ofm_drain sequencer
//   - WORD_W        : width of one packed OFM word
//   - BYTE_W        : width of one MAC result byte
//   - BYTES_PER_WORD: results packed into one word
//   - BIDX_W        : width of a byte index inside a word
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } drain_state_t;

endpackage : cnn_pkg

// File: rtl/word_unpacker.sv
// -----------------------------------------------------------------------------
// word_unpacker
// Holds one OFM word and presents it as a byte stream, most significant byte
// first (the packer shifts new results in at the LSB, so the oldest result
// sits in the top byte).
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   clear_i      in   reset the byte index (start of a drain)
//   load_i       in   capture word_i into the word register, byte index -> 0
//   word_i       in   word to capture
//   emit_i       in   the current byte is being offered downstream
//   ready_i      in   downstream accepts the offered byte
//   byte_o       out  currently selected byte (stable until accepted)
//   valid_o      out  byte_o is valid
//   last_byte_o  out  the final byte of the word is accepted this cycle
// -----------------------------------------------------------------------------
module word_unpacker
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              emit_i,
    input  logic              ready_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              valid_o,
    output logic              last_byte_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [BIDX_W-1:0] idx_q,  idx_d;
    logic              accept;

    // Lane 0 is the most significant byte.
    logic [BYTE_W-1:0] lanes [BYTES_PER_WORD];

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign lanes[gi] = word_q[WORD_W-1-gi*BYTE_W -: BYTE_W];
        end
    endgenerate

    assign accept      = emit_i && ready_i;
    assign valid_o     = emit_i;
    assign byte_o      = lanes[idx_q];
    assign last_byte_o = accept && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = word_i;
        end
        if (clear_i || load_i) begin
            idx_d = '0;
        end else if (accept) begin
            // Wraps to 0 after the last byte, which leaves the index cleared
            // for the next word.
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule : word_unpacker

// File: rtl/ofm_drain.sv
// -----------------------------------------------------------------------------
// ofm_drain
// Walks the per-PE OFM memories after convolution, reading word_count words
// per channel starting at base_addr, for channels 0..CH_NUM-1 in order, and
// streams every word out as four bytes (MSB first) over valid/ready.
// Cost per word with the consumer always ready: READ, WAIT, 4x EMIT.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset (abandons a drain)
//   start       in   one-cycle request, only honoured in IDLE
//   base_addr   in   first word address for every channel (latched on start)
//   word_count  in   words per channel (latched on start)
//   ch_sel      out  channel being read (meaningful only while mem_re)
//   mem_addr    out  word address (meaningful only while mem_re)
//   mem_re      out  read strobe, data returns on mem_rdata one cycle later
//   mem_rdata   in   read data from the selected OFM
//   byte_out    out  unpacked byte
//   byte_valid  out  byte_out valid
//   byte_ready  in   consumer accepts byte_out
//   busy        out  high outside IDLE
//   done        out  one-cycle pulse when the drain finishes
// -----------------------------------------------------------------------------
module ofm_drain
    import cnn_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [CH_W-1:0]   ch_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done
);

    drain_state_t      state_q, state_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [CH_W-1:0]   ch_q,    ch_d;
    logic [ADDR_W-1:0] off_q,   off_d;
    // Last issued address/channel, so the memory-side outputs stay quiet
    // between reads instead of following the sequencing counters.
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [CH_W-1:0]   ch_hold_q,   ch_hold_d;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   off_inc;
    logic              more_words;
    logic              more_chans;
    logic              unp_clear;
    logic              unp_load;
    logic              unp_emit;
    logic              last_byte;

    // Address arithmetic wraps modulo 2**ADDR_W by construction.
    assign rd_addr    = base_q + off_q;
    // One extra bit so offset+1 cannot overflow before the comparison.
    assign off_inc    = {1'b0, off_q} + (ADDR_W+1)'(1);
    assign more_words = off_inc < {1'b0, count_q};
    assign more_chans = ch_q < CH_W'(CH_NUM - 1);

    assign unp_load = (state_q == ST_WAIT);
    assign unp_emit = (state_q == ST_EMIT);

    word_unpacker u_unpacker (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (unp_clear),
        .load_i      (unp_load),
        .word_i      (mem_rdata),
        .emit_i      (unp_emit),
        .ready_i     (byte_ready),
        .byte_o      (byte_out),
        .valid_o     (byte_valid),
        .last_byte_o (last_byte)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        ch_d        = ch_q;
        off_d       = off_q;
        addr_hold_d = addr_hold_q;
        ch_hold_d   = ch_hold_q;
        unp_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    count_d   = word_count;
                    ch_d      = '0;
                    off_d     = '0;
                    unp_clear = 1'b1;
                    state_d   = (word_count == '0) ? ST_FIN : ST_READ;
                end
            end
            ST_READ: begin
                addr_hold_d = rd_addr;
                ch_hold_d   = ch_q;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (last_byte) begin
                    if (more_words) begin
                        off_d   = off_inc[ADDR_W-1:0];
                        state_d = ST_READ;
                    end else if (more_chans) begin
                        ch_d    = ch_q + 1'b1;
                        off_d   = '0;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            ch_q        <= '0;
            off_q       <= '0;
            addr_hold_q <= '0;
            ch_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            ch_q        <= ch_d;
            off_q       <= off_d;
            addr_hold_q <= addr_hold_d;
            ch_hold_q   <= ch_hold_d;
        end
    end

    // All outputs decode registered state only, so an asynchronous reset
    // forces every one of them to zero immediately.
    assign mem_re   = (state_q == ST_READ);
    assign mem_addr = mem_re ? rd_addr : addr_hold_q;
    assign ch_sel   = mem_re ? ch_q    : ch_hold_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);

endmodule : ofm_drain

// File: tb/tb_ofm_drain.sv
// -----------------------------------------------------------------------------
// tb_ofm_drain
// Randomised bench for ofm_drain. The expected read sequence and byte stream
// are built directly from the drain rules (channels in order, base+offset
// modulo 1024, four bytes MSB first). A memory model returns data exactly one
// cycle after mem_re and junk otherwise.
// -----------------------------------------------------------------------------
module tb_ofm_drain;

    localparam int CH_NUM = 4;
    localparam int CH_W   = 2;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] word_count = '0;
    logic [CH_W-1:0]   ch_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata = '0;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              byte_ready = 1'b1;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    ofm_drain #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .ch_sel     (ch_sel),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem [CH_NUM][DEPTH];
    logic [7:0]  exp_bytes [$];
    logic [11:0] exp_reads [$];
    int          bidx = 0;
    int          ridx = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    bit          rand_mode = 1'b0;
    bit          stall_arm = 1'b0;
    int          stall_left = 0;
    bit          pend_valid = 1'b0;
    logic [31:0] pend_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; drive inputs and observe outputs 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        // Memory: data for a read seen in the previous cycle, junk otherwise.
        mem_rdata  = pend_valid ? pend_data : $urandom();
        pend_valid = (mem_re === 1'b1);
        pend_data  = mem[ch_sel][mem_addr];
        // Consumer.
        if (stall_arm && byte_valid && (bidx % 4 == 1)) begin
            stall_left = 3;
            stall_arm  = 1'b0;
        end
        if (stall_left > 0) begin
            byte_ready = 1'b0;
            stall_left--;
        end else if (rand_mode) begin
            byte_ready = ($urandom_range(0, 99) < 65);
        end else begin
            byte_ready = 1'b1;
        end
        // Byte stream: whatever is offered must be the next expected byte,
        // including every cycle of a stall.
        if (byte_valid) begin
            if (bidx < exp_bytes.size())
                chk(byte_ready ? "byte" : "byte_held", 32'(byte_out), 32'(exp_bytes[bidx]));
            else
                chk("byte_extra", 32'(byte_valid), 0);
            if (byte_ready) bidx++;
        end
        if (mem_re) begin
            if (ridx < exp_reads.size())
                chk("rd_ch_addr", 32'({ch_sel, mem_addr}), 32'(exp_reads[ridx]));
            else
                chk("rd_extra", 32'(mem_re), 0);
            ridx++;
        end
        if (done) done_cnt++;
    endtask

    task automatic push_expected(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
        logic [ADDR_W-1:0] a;
        logic [31:0]       w;
        for (int c = 0; c < CH_NUM; c++) begin
            for (int o = 0; o < int'(n); o++) begin
                a = b + ADDR_W'(o);
                exp_reads.push_back({CH_W'(c), a});
                w = mem[c][a];
                for (int k = 0; k < 4; k++) exp_bytes.push_back(w[31-8*k -: 8]);
            end
        end
    endtask

    task automatic run_drain(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n,
                             input bit rnd, input bit poke, input bit stall1);
        int k = 0;
        int k_re = 0;
        int k_v = 0;
        int d0 = done_cnt;
        int budget = 100 + 40 * CH_NUM * int'(n);
        bit got_done = 1'b0;
        bit poked = 1'b0;
        push_expected(b, n);
        rand_mode  = rnd;
        stall_arm  = stall1;
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        while (!got_done && k < budget) begin
            tick();
            k++;
            start = 1'b0;
            if (poke && !poked && byte_valid) begin
                // Must be ignored: drain is already running.
                start      = 1'b1;
                base_addr  = ADDR_W'($urandom());
                word_count = ADDR_W'($urandom_range(1, 5));
                poked      = 1'b1;
            end
            if (mem_re && k_re == 0) k_re = k;
            if (byte_valid && k_v == 0) k_v = k;
            got_done = (done === 1'b1);
        end
        chk("drain_timeout", 32'(!got_done), 0);
        chk("busy_in_fin", 32'(busy), 1);
        if (!rnd && !stall1) begin
            chk("done_cycle", k, 6 * CH_NUM * int'(n) + 1);
            if (n != 0) begin
                chk("first_re_cycle", k_re, 1);
                chk("first_valid_cycle", k_v, 3);
            end
        end
        rand_mode = 1'b0;
        tick();
        chk("busy_after_fin", 32'(busy), 0);
        chk("done_single_cycle", 32'(done), 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("bytes_all", bidx, exp_bytes.size());
        chk("reads_all", ridx, exp_reads.size());
        $display("drain base=%0d count=%0d rnd=%0d poke=%0d stall=%0d cycles=%0d bytes=%0d",
                 b, n, rnd, poke, stall1, k, bidx);
    endtask

    initial begin
        int r0;
        int k;
        int d0;
        for (int c = 0; c < CH_NUM; c++)
            for (int a = 0; a < DEPTH; a++) mem[c][a] = $urandom();
        for (int c = 0; c < CH_NUM; c++)
            for (int o = 0; o < 2; o++) mem[c][o] = {8'(c), 8'(o), 8'h00, 8'hFF};
        mem[0][5] = 32'hA1B2_C3D4;

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_valid", 32'(byte_valid), 0);
        chk("rst_byte", 32'(byte_out), 0);
        chk("rst_ch_sel", 32'(ch_sel), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        rst = 1'b0;
        tick();

        run_drain(10'd5, 10'd1, 1'b0, 1'b0, 1'b0);    // A1 B2 C3 D4 first
        run_drain(10'd0, 10'd2, 1'b0, 1'b0, 1'b0);    // {ch,off,00,FF} pattern
        run_drain(10'd5, 10'd1, 1'b0, 1'b0, 1'b1);    // 3-cycle stall on B2
        run_drain(10'd77, 10'd3, 1'b1, 1'b0, 1'b1);   // stall plus random ready
        run_drain(10'd300, 10'd0, 1'b0, 1'b0, 1'b0);  // empty drain
        run_drain(10'd1023, 10'd2, 1'b0, 1'b0, 1'b0); // address wrap
        run_drain(10'd10, 10'd2, 1'b0, 1'b1, 1'b0);   // start during EMIT

        // Reset in the middle of word 2.
        r0 = ridx;
        d0 = done_cnt;
        k  = 0;
        push_expected(10'd100, 10'd3);
        start      = 1'b1;
        base_addr  = 10'd100;
        word_count = 10'd3;
        do begin
            tick();
            start = 1'b0;
            k++;
        end while (!((ridx - r0) >= 2 && byte_valid) && k < 200);
        chk("rst_setup_timeout", 32'(k >= 200), 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(byte_valid), 0);
        chk("arst_byte", 32'(byte_out), 0);
        chk("arst_mem_re", 32'(mem_re), 0);
        chk("arst_ch_sel", 32'(ch_sel), 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_done", 32'(done), 0);
        repeat (2) tick();
        while (exp_bytes.size() > bidx) void'(exp_bytes.pop_back());
        while (exp_reads.size() > ridx) void'(exp_reads.pop_back());
        rst = 1'b0;
        repeat (6) begin
            tick();
            chk("post_rst_idle_busy", 32'(busy), 0);
        end
        chk("post_rst_no_done", done_cnt - d0, 0);
        $display("reset abort: bytes delivered=%0d", bidx);
        run_drain(10'd100, 10'd3, 1'b0, 1'b0, 1'b0);  // clean restart

        for (int t = 0; t < 4; t++)
            run_drain(ADDR_W'($urandom()), ADDR_W'($urandom_range(1, 4)), 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ofm_drain
